// File: rtl/qs_fifo_pkg.sv
// -----------------------------------------------------------------------------
// qs_fifo_pkg
// Types and default constants shared by the QS FIFO and its burst reader.
//   rd_state_t      : burst reader FSM state encoding
//   DEF_DATA_W      : default data word width
//   DEF_BURST_LEN   : default beats per burst
//   DEF_GAP_CYCLES  : default idle cycles between bursts
//   cnt_width()     : width of a counter that must reach max_val (min 1 bit)
// -----------------------------------------------------------------------------
package qs_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } rd_state_t;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_BURST_LEN  = 4;
  localparam int DEF_GAP_CYCLES = 1;

  // $clog2(max_val+1), but never zero so a counter for max_val=0 still
  // has a legal (unused) 1-bit declaration.
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/qs_out_stage.sv
// -----------------------------------------------------------------------------
// qs_out_stage
// Single output register for the burst reader. A load captures the popped
// FIFO word and raises valid; the beat is held unchanged until it is taken
// (valid_o & ready_i). A load while the held beat drains replaces it in the
// same edge, giving one beat per cycle.
// Optional feature macro: QS_FIFO_READER_PARITY_EN adds par_o, the XOR of
// the registered data word.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   load_i      : capture data_i/last_i at the next edge
//   data_i      : word to capture
//   last_i      : captured word is the final beat of the burst
//   ready_i     : downstream accepts the held beat
//   valid_o     : held beat is valid
//   data_o      : held beat data
//   last_o      : held beat is the final beat
//   par_o       : (parity build only) XOR of data_o
// -----------------------------------------------------------------------------
module qs_out_stage
  import qs_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o
`ifdef QS_FIFO_READER_PARITY_EN
  ,
  output logic              par_o
`endif
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
`ifdef QS_FIFO_READER_PARITY_EN
  logic              par_q, par_d;
`endif

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
`ifdef QS_FIFO_READER_PARITY_EN
    par_d   = par_q;
`endif
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
`ifdef QS_FIFO_READER_PARITY_EN
      par_d   = ^data_i;
`endif
    end else if (valid_q && ready_i) begin
      // Beat taken with nothing behind it: data/last may keep stale
      // values, they are only meaningful while valid is high.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
`ifdef QS_FIFO_READER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
`ifdef QS_FIFO_READER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
`ifdef QS_FIFO_READER_PARITY_EN
  assign par_o   = par_q;
`endif

endmodule

// File: rtl/qs_fifo_reader.sv
// -----------------------------------------------------------------------------
// qs_fifo_reader
// Reads bursts of BURST_LEN words from an upstream FIFO whose head word is
// visible combinationally (pop_data_i valid with pop_o) and streams them
// downstream over a valid/ready interface, marking the final beat with
// out_last_o. GAP_CYCLES idle cycles separate consecutive bursts.
// Optional feature macro: QS_FIFO_READER_PARITY_EN adds out_par_o.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   en_i         : permission to start a new burst (sampled in idle only)
//   empty_i      : upstream FIFO empty
//   pop_o        : pop upstream FIFO this cycle
//   pop_data_i   : upstream FIFO head word
//   out_valid_o  : downstream beat valid
//   out_ready_i  : downstream accepts beat
//   out_data_o   : beat data
//   out_last_o   : final beat of the burst
//   busy_o       : FSM not idle
//   out_par_o    : (parity build only) XOR of out_data_o
// -----------------------------------------------------------------------------
module qs_fifo_reader
  import qs_fifo_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic              empty_i,
  output logic              pop_o,
  input  logic [DATA_W-1:0] pop_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic              busy_o
`ifdef QS_FIFO_READER_PARITY_EN
  ,
  output logic              out_par_o
`endif
);

  localparam int PW = cnt_width(BURST_LEN);
  localparam int GW = cnt_width(GAP_CYCLES);

  localparam logic [PW-1:0] BURST_LEN_C = PW'(BURST_LEN);
  localparam logic [PW-1:0] LAST_IDX_C  = PW'(BURST_LEN - 1);
  localparam logic [PW-1:0] ONE_P       = PW'(1);
  localparam logic [GW-1:0] GAP_LAST_C  = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  localparam logic [GW-1:0] ONE_G       = GW'(1);

  rd_state_t         state_q, state_d;
  logic [PW-1:0]     pops_done_q, pops_done_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic              busy_q, busy_d;

  logic              pop;
  logic              last_pop;
  logic              last_xfer;

  // Pop only while the output register can take the word this edge:
  // either it is empty or its current beat leaves at the same edge.
  always_comb begin
    pop       = (state_q == ST_BURST) && !empty_i &&
                (!out_valid_o || out_ready_i) &&
                (pops_done_q < BURST_LEN_C);
    last_pop  = pop && (pops_done_q == LAST_IDX_C);
    last_xfer = out_valid_o && out_ready_i && out_last_o;
  end

  always_comb begin
    state_d     = state_q;
    pops_done_d = pops_done_q;
    gap_cnt_d   = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        // Counters are held at zero while idle so every burst starts clean.
        pops_done_d = '0;
        gap_cnt_d   = '0;
        if (en_i && !empty_i) begin
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        // en_i is ignored here: once started a burst always completes.
        if (pop) begin
          pops_done_d = pops_done_q + ONE_P;
        end
        if (last_xfer) begin
          if (GAP_CYCLES > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
          end else begin
            state_d   = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST_C) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + ONE_G;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Registered busy follows the state register exactly.
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pops_done_q <= '0;
      gap_cnt_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pops_done_q <= pops_done_d;
      gap_cnt_q   <= gap_cnt_d;
      busy_q      <= busy_d;
    end
  end

  // pop is a function of state_q, so it is already 0 while reset holds
  // the FSM in idle.
  assign pop_o  = pop;
  assign busy_o = busy_q;

  qs_out_stage #(
    .DATA_W (DATA_W)
  ) u_out_stage (
    .clk     (clk),
    .reset   (reset),
    .load_i  (pop),
    .data_i  (pop_data_i),
    .last_i  (last_pop),
    .ready_i (out_ready_i),
    .valid_o (out_valid_o),
    .data_o  (out_data_o),
    .last_o  (out_last_o)
`ifdef QS_FIFO_READER_PARITY_EN
    ,
    .par_o   (out_par_o)
`endif
  );

endmodule

// File: tb/tb_qs_fifo_reader.sv
// -----------------------------------------------------------------------------
// tb_qs_fifo_reader
// Directed bench for qs_fifo_reader. u_dut uses BURST_LEN=4, GAP_CYCLES=3;
// u_b uses BURST_LEN=1, GAP_CYCLES=0. A small array FIFO model feeds u_dut
// and a monitor logs every transferred beat with its cycle number.
// Build with QS_FIFO_READER_PARITY_EN defined to exercise out_par_o.
// -----------------------------------------------------------------------------
module tb_qs_fifo_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       en_i;
  logic       empty_i;
  logic       pop_o;
  logic [7:0] pop_data_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [7:0] out_data_o;
  logic       out_last_o;
  logic       busy_o;
`ifdef QS_FIFO_READER_PARITY_EN
  logic       out_par_o;
  logic       out_par_b;
`endif

  logic       en_b;
  logic       empty_b;
  logic       pop_b;
  logic [7:0] src_b = 8'h00;
  logic       out_valid_b;
  logic [7:0] out_data_b;
  logic       out_last_b;
  logic       busy_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // FIFO model: pushes from the stimulus process, pops from the monitor.
  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign empty_i    = (wr_ptr == rd_ptr);
  assign pop_data_i = empty_i ? 8'h00 : mem[rd_ptr[5:0]];

  assign empty_b = 1'b0;

  logic [7:0] beat_data [$];
  logic       beat_last [$];
  int         beat_cyc  [$];

  always #5 clk = ~clk;

  qs_fifo_reader #(
    .DATA_W     (8),
    .BURST_LEN  (4),
    .GAP_CYCLES (3)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .en_i        (en_i),
    .empty_i     (empty_i),
    .pop_o       (pop_o),
    .pop_data_i  (pop_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .busy_o      (busy_o)
`ifdef QS_FIFO_READER_PARITY_EN
    ,
    .out_par_o   (out_par_o)
`endif
  );

  qs_fifo_reader #(
    .DATA_W     (8),
    .BURST_LEN  (1),
    .GAP_CYCLES (0)
  ) u_b (
    .clk         (clk),
    .reset       (reset),
    .en_i        (en_b),
    .empty_i     (empty_b),
    .pop_o       (pop_b),
    .pop_data_i  (src_b),
    .out_valid_o (out_valid_b),
    .out_ready_i (1'b1),
    .out_data_o  (out_data_b),
    .out_last_o  (out_last_b),
    .busy_o      (busy_b)
`ifdef QS_FIFO_READER_PARITY_EN
    ,
    .out_par_o   (out_par_b)
`endif
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && pop_o) rd_ptr <= rd_ptr + 1;
    if (!reset && pop_b) src_b <= src_b + 8'h01;
    if (!reset && out_valid_o && out_ready_i) begin
      beat_data.push_back(out_data_o);
      beat_last.push_back(out_last_o);
      beat_cyc.push_back(cyc);
      $display("beat cyc=%0d data=%h last=%b", cyc, out_data_o, out_last_o);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  task automatic push_word(input logic [7:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid_o); end
    checks++; if (out_last_o !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", out_last_o); end
    checks++; if (out_data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", out_data_o); end
    checks++; if (pop_o !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b expected 0", pop_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    @(negedge clk);
    reset = 1'b0;
    $display("reset released at cyc=%0d", cyc);
  endtask

  task automatic test_basic();
    int base, e;
    logic [7:0] exp_d;
    for (int i = 0; i < 4; i++) push_word(8'h11 + 8'(i));
    @(negedge clk);
    base = beat_data.size(); e = cyc; en_i = 1'b1;
    @(negedge clk);
    en_i = 1'b0;
    repeat (12) @(negedge clk);
    checks++; if (beat_data.size() - base !== 4) begin errors++; $display("FAIL basic_count: got %0d expected 4", beat_data.size() - base); end
    if (beat_data.size() - base >= 4) begin
      checks++; if (beat_cyc[base] !== e + 2) begin errors++; $display("FAIL basic_latency: got cyc %0d expected %0d", beat_cyc[base], e + 2); end
      for (int i = 0; i < 4; i++) begin
        exp_d = 8'h11 + 8'(i);
        checks++; if (beat_data[base+i] !== exp_d) begin errors++; $display("FAIL basic_data%0d: got %h expected %h", i, beat_data[base+i], exp_d); end
        checks++; if (beat_last[base+i] !== (i == 3)) begin errors++; $display("FAIL basic_last%0d: got %b expected %b", i, beat_last[base+i], i == 3); end
        checks++; if (beat_cyc[base+i] !== e + 2 + i) begin errors++; $display("FAIL basic_cyc%0d: got %0d expected %0d", i, beat_cyc[base+i], e + 2 + i); end
      end
    end
  endtask

  task automatic test_stall();
    int base, e, k;
    logic [7:0] exp_d;
    for (int i = 0; i < 4; i++) push_word(8'h21 + 8'(i));
    @(negedge clk);
    base = beat_data.size(); e = cyc; en_i = 1'b1;
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      k = cyc - e;
      en_i = 1'b0;
      if (k == 3) out_ready_i = 1'b0;
      if (k == 6) out_ready_i = 1'b1;
      #1;
      if (k >= 3 && k <= 5) begin
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid k=%0d: got %b expected 1", k, out_valid_o); end
        checks++; if (out_data_o !== 8'h22) begin errors++; $display("FAIL stall_data k=%0d: got %h expected 22", k, out_data_o); end
        checks++; if (pop_o !== 1'b0) begin errors++; $display("FAIL stall_pop k=%0d: got %b expected 0", k, pop_o); end
      end
    end
    checks++; if (beat_data.size() - base !== 4) begin errors++; $display("FAIL stall_count: got %0d expected 4", beat_data.size() - base); end
    if (beat_data.size() - base >= 4) begin
      for (int i = 0; i < 4; i++) begin
        exp_d = 8'h21 + 8'(i);
        checks++; if (beat_data[base+i] !== exp_d) begin errors++; $display("FAIL stall_data%0d: got %h expected %h", i, beat_data[base+i], exp_d); end
      end
      checks++; if (beat_last[base+3] !== 1'b1) begin errors++; $display("FAIL stall_last: got %b expected 1", beat_last[base+3]); end
    end
  endtask

  task automatic test_underflow();
    int base, e, k;
    logic [7:0] exp_d;
    push_word(8'h31); push_word(8'h32);
    @(negedge clk);
    base = beat_data.size(); e = cyc; en_i = 1'b1;
    for (int n = 0; n < 13; n++) begin
      @(negedge clk);
      k = cyc - e;
      en_i = 1'b0;
      if (k == 5) begin push_word(8'h33); push_word(8'h34); end
      #1;
      if (k == 4) begin
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL under_valid_gap: got %b expected 0", out_valid_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL under_busy: got %b expected 1", busy_o); end
      end
    end
    checks++; if (beat_data.size() - base !== 4) begin errors++; $display("FAIL under_count: got %0d expected 4", beat_data.size() - base); end
    if (beat_data.size() - base >= 4) begin
      for (int i = 0; i < 4; i++) begin
        exp_d = 8'h31 + 8'(i);
        checks++; if (beat_data[base+i] !== exp_d) begin errors++; $display("FAIL under_data%0d: got %h expected %h", i, beat_data[base+i], exp_d); end
        checks++; if (beat_last[base+i] !== (i == 3)) begin errors++; $display("FAIL under_last%0d: got %b expected %b", i, beat_last[base+i], i == 3); end
      end
      checks++; if (beat_cyc[base+2] !== e + 6) begin errors++; $display("FAIL under_resume: got cyc %0d expected %0d", beat_cyc[base+2], e + 6); end
    end
  endtask

  task automatic test_gap();
    int base, e, k;
    logic [7:0] exp_d;
    for (int i = 0; i < 8; i++) push_word(8'h41 + 8'(i));
    @(negedge clk);
    base = beat_data.size(); e = cyc; en_i = 1'b1;
    for (int n = 0; n < 19; n++) begin
      @(negedge clk);
      k = cyc - e;
      #1;
      if (k >= 6 && k <= 8) begin
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL gap_busy k=%0d: got %b expected 1", k, busy_o); end
        checks++; if (pop_o !== 1'b0) begin errors++; $display("FAIL gap_pop k=%0d: got %b expected 0", k, pop_o); end
      end
      if (k == 9) begin
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL gap_idle_busy: got %b expected 0", busy_o); end
        checks++; if (pop_o !== 1'b0) begin errors++; $display("FAIL gap_idle_pop: got %b expected 0", pop_o); end
      end
      if (k == 10) begin
        checks++; if (pop_o !== 1'b1) begin errors++; $display("FAIL gap_second_pop: got %b expected 1", pop_o); end
        en_i = 1'b0;
      end
    end
    checks++; if (beat_data.size() - base !== 8) begin errors++; $display("FAIL gap_count: got %0d expected 8", beat_data.size() - base); end
    if (beat_data.size() - base >= 8) begin
      for (int i = 0; i < 8; i++) begin
        exp_d = 8'h41 + 8'(i);
        checks++; if (beat_data[base+i] !== exp_d) begin errors++; $display("FAIL gap_data%0d: got %h expected %h", i, beat_data[base+i], exp_d); end
        checks++; if (beat_last[base+i] !== (i == 3 || i == 7)) begin errors++; $display("FAIL gap_last%0d: got %b expected %b", i, beat_last[base+i], (i == 3 || i == 7)); end
      end
      checks++; if (beat_cyc[base+4] !== e + 11) begin errors++; $display("FAIL gap_second_start: got cyc %0d expected %0d", beat_cyc[base+4], e + 11); end
    end
  endtask

`ifdef QS_FIFO_READER_PARITY_EN
  task automatic test_parity();
    int e, k;
    push_word(8'h07); push_word(8'h03); push_word(8'h05); push_word(8'h06);
    @(negedge clk);
    e = cyc; en_i = 1'b1;
    for (int n = 0; n < 13; n++) begin
      @(negedge clk);
      k = cyc - e;
      en_i = 1'b0;
      #1;
      if (k == 2) begin
        checks++; if (out_data_o !== 8'h07) begin errors++; $display("FAIL par_data07: got %h expected 07", out_data_o); end
        checks++; if (out_par_o !== 1'b1) begin errors++; $display("FAIL par_07: got %b expected 1", out_par_o); end
      end
      if (k == 3) begin
        checks++; if (out_data_o !== 8'h03) begin errors++; $display("FAIL par_data03: got %h expected 03", out_data_o); end
        checks++; if (out_par_o !== 1'b0) begin errors++; $display("FAIL par_03: got %b expected 0", out_par_o); end
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    int base0, base, e, k;
    logic [7:0] exp_d;
    for (int i = 0; i < 8; i++) push_word(8'h51 + 8'(i));
    @(negedge clk);
    base0 = beat_data.size(); e = cyc; en_i = 1'b1;
    k = 0;
    while (k < 3) begin
      @(negedge clk);
      k = cyc - e;
      en_i = 1'b0;
    end
    reset = 1'b1;
    #1;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", out_valid_o); end
    checks++; if (out_data_o !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", out_data_o); end
    checks++; if (pop_o !== 1'b0) begin errors++; $display("FAIL rstmid_pop: got %b expected 0", pop_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy_o); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    base = beat_data.size(); e = cyc; en_i = 1'b1;
    checks++; if (base - base0 !== 1) begin errors++; $display("FAIL rstmid_pre_beats: got %0d expected 1", base - base0); end
    @(negedge clk);
    en_i = 1'b0;
    repeat (12) @(negedge clk);
    checks++; if (beat_data.size() - base !== 4) begin errors++; $display("FAIL rstmid_count: got %0d expected 4", beat_data.size() - base); end
    if (beat_data.size() - base >= 4) begin
      checks++; if (beat_cyc[base] !== e + 2) begin errors++; $display("FAIL rstmid_latency: got cyc %0d expected %0d", beat_cyc[base], e + 2); end
      for (int i = 0; i < 4; i++) begin
        exp_d = 8'h53 + 8'(i);
        checks++; if (beat_data[base+i] !== exp_d) begin errors++; $display("FAIL rstmid_data%0d: got %h expected %h", i, beat_data[base+i], exp_d); end
        checks++; if (beat_last[base+i] !== (i == 3)) begin errors++; $display("FAIL rstmid_last%0d: got %b expected %b", i, beat_last[base+i], i == 3); end
      end
    end
  endtask

  task automatic test_burst_len1();
    int nb, prev;
    logic [7:0] exp_d;
    nb = 0; prev = -1; exp_d = 8'h00;
    @(negedge clk);
    en_b = 1'b1;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      #1;
      if (out_valid_b === 1'b1) begin
        $display("len1 beat cyc=%0d data=%h last=%b", cyc, out_data_b, out_last_b);
        checks++; if (out_last_b !== 1'b1) begin errors++; $display("FAIL len1_last%0d: got %b expected 1", nb, out_last_b); end
        checks++; if (out_data_b !== exp_d) begin errors++; $display("FAIL len1_data%0d: got %h expected %h", nb, out_data_b, exp_d); end
        checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL len1_busy%0d: got %b expected 1", nb, busy_b); end
        if (prev >= 0) begin
          checks++; if (cyc - prev !== 3) begin errors++; $display("FAIL len1_period%0d: got %0d expected 3", nb, cyc - prev); end
        end
        prev = cyc; exp_d = exp_d + 8'h01; nb++;
      end
    end
    en_b = 1'b0;
    checks++; if (nb !== 5) begin errors++; $display("FAIL len1_count: got %0d expected 5", nb); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset       = 1'b1;
    en_i        = 1'b0;
    out_ready_i = 1'b1;
    en_b        = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_underflow();
    test_gap();
`ifdef QS_FIFO_READER_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    test_burst_len1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
